// File: rtl/one_hot_victim_select.sv
// One-hot cache victim selector: prefers invalid ways, never picks locked
// ways, and otherwise picks by fixed, round-robin or LFSR mode.
// Ports: clock/reset (async, active-high); mode, fixed_way, way_valid,
// way_lock, request and commit in; victim_valid, victim_onehot,
// victim_index and victim_none out. All outputs come straight from flops.
module one_hot_victim_select #(
   parameter int  WAYS  = 8,
   localparam int IDX_W = $clog2(WAYS)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic [IDX_W-1:0] fixed_way,
   input  logic [WAYS-1:0]  way_valid,
   input  logic [WAYS-1:0]  way_lock,
   input  logic             request,
   input  logic             commit,
   output logic             victim_valid,
   output logic [WAYS-1:0]  victim_onehot,
   output logic [IDX_W-1:0] victim_index,
   output logic             victim_none
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_MASK = 16'hB400;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [15:0]      lfsr_q, lfsr_d;
   logic             valid_q, valid_d;
   logic [WAYS-1:0]  onehot_q, onehot_d;
   logic [IDX_W-1:0] index_q, index_d;
   logic             none_q, none_d;

   logic [WAYS-1:0]  free;
   logic [IDX_W-1:0] start;
   logic [IDX_W-1:0] cand;
   logic [IDX_W-1:0] sel_idx;
   logic             sel_none;
   logic [WAYS-1:0]  sel_onehot;

   // Victim choice from current inputs and state.
   // Loops run downward so the lowest qualifying candidate wins.
   always_comb begin
      free     = ~way_valid & ~way_lock;
      start    = '0;
      cand     = '0;
      sel_idx  = '0;
      sel_none = 1'b0;
      if (|free) begin
         for (int i = WAYS - 1; i >= 0; i--) begin
            if (free[i]) sel_idx = IDX_W'(i);
         end
      end else if (mode == 2'd0) begin
         sel_idx  = fixed_way;
         sel_none = way_lock[fixed_way];
      end else begin
         start    = (mode == 2'd2) ? lfsr_q[IDX_W-1:0] : rr_ptr_q;
         sel_none = 1'b1;
         for (int k = WAYS - 1; k >= 0; k--) begin
            // Width-limited add gives the wrap-around scan.
            cand = start + IDX_W'(k);
            if (!way_lock[cand]) begin
               sel_idx  = cand;
               sel_none = 1'b0;
            end
         end
      end
      if (sel_none) sel_idx = '0;
      sel_onehot = sel_none ? '0 : (WAYS'(1) << sel_idx);
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      valid_d  = valid_q;
      onehot_d = onehot_q;
      index_d  = index_q;
      none_d   = none_q;
      // Galois shift; the seed is non-zero so the register never locks up.
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
      unique case (state_q)
         IDLE: begin
            if (request) begin
               valid_d  = 1'b1;
               onehot_d = sel_onehot;
               index_d  = sel_idx;
               none_d   = sel_none;
               state_d  = HOLD;
            end
         end
         HOLD: begin
            if (commit) begin
               if (!none_q) rr_ptr_d = index_q + 1'b1;
               valid_d = 1'b0;
               none_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         lfsr_q   <= LFSR_SEED;
         valid_q  <= 1'b0;
         onehot_q <= '0;
         index_q  <= '0;
         none_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         lfsr_q   <= lfsr_d;
         valid_q  <= valid_d;
         onehot_q <= onehot_d;
         index_q  <= index_d;
         none_q   <= none_d;
      end
   end

   assign victim_valid  = valid_q;
   assign victim_onehot = onehot_q;
   assign victim_index  = index_q;
   assign victim_none   = none_q;

endmodule

// File: tb/tb_one_hot_victim_select.sv
// Directed bench for one_hot_victim_select with WAYS=4.
// Observed bundle is {valid, onehot[3:0], index[1:0], none}.
module tb_one_hot_victim_select;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] mode = 2'd1;
   logic [1:0] fixed_way = 2'd0;
   logic [3:0] way_valid = 4'hF;
   logic [3:0] way_lock = 4'h0;
   logic       request = 1'b0;
   logic       commit = 1'b0;
   logic       victim_valid;
   logic [3:0] victim_onehot;
   logic [1:0] victim_index;
   logic       victim_none;
   logic [7:0] obs;

   int pass_cnt = 0;
   int total = 0;

   assign obs = {victim_valid, victim_onehot, victim_index, victim_none};

   one_hot_victim_select #(.WAYS(4)) dut (
      .clock(clock),
      .reset(reset),
      .mode(mode),
      .fixed_way(fixed_way),
      .way_valid(way_valid),
      .way_lock(way_lock),
      .request(request),
      .commit(commit),
      .victim_valid(victim_valid),
      .victim_onehot(victim_onehot),
      .victim_index(victim_index),
      .victim_none(victim_none)
   );

   always #5 clock = ~clock;

   task automatic do_req();
      request = 1'b1;
      @(posedge clock); #1;
      request = 1'b0;
   endtask

   task automatic do_commit();
      commit = 1'b1;
      @(posedge clock); #1;
      commit = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      mode = 2'd1; way_valid = 4'hF; way_lock = 4'h0;
      do_reset();
      total++;
      if (obs !== 8'b0_0000_00_0)
         $display("FAIL reset_outputs got %b want %b", obs, 8'b0_0000_00_0);
      else pass_cnt++;
   endtask

   task automatic test_rr_wrap();
      logic [7:0] exp [5];
      exp[0] = 8'b1_0001_00_0;
      exp[1] = 8'b1_0010_01_0;
      exp[2] = 8'b1_0100_10_0;
      exp[3] = 8'b1_1000_11_0;
      exp[4] = 8'b1_0001_00_0;
      mode = 2'd1; way_valid = 4'hF; way_lock = 4'h0;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         do_req();
         total++;
         if (obs !== exp[i])
            $display("FAIL rr_wrap_%0d got %b want %b", i, obs, exp[i]);
         else pass_cnt++;
         do_commit();
         total++;
         if ({victim_valid, victim_none} !== 2'b00)
            $display("FAIL rr_commit_%0d got %b want 00", i,
                     {victim_valid, victim_none});
         else pass_cnt++;
      end
   endtask

   task automatic test_invalid_pref();
      mode = 2'd1; way_valid = 4'b1011; way_lock = 4'h0;
      do_reset();
      do_req();
      total++;
      if (obs !== 8'b1_0100_10_0)
         $display("FAIL invalid_pref got %b want %b", obs, 8'b1_0100_10_0);
      else pass_cnt++;
      do_commit();
      way_valid = 4'b0111; way_lock = 4'b1000;
      do_req();
      total++;
      if (obs !== 8'b1_0001_00_0)
         $display("FAIL locked_invalid_rr got %b want %b", obs,
                  8'b1_0001_00_0);
      else pass_cnt++;
      do_commit();
   endtask

   task automatic test_rr_lock();
      mode = 2'd3; way_valid = 4'hF; way_lock = 4'b0010;
      // rr_ptr is 1 after the previous test's commit of way 0
      do_req();
      total++;
      if (obs !== 8'b1_0100_10_0)
         $display("FAIL rr_skip_lock got %b want %b", obs, 8'b1_0100_10_0);
      else pass_cnt++;
      do_commit();
      way_lock = 4'hF;
      do_req();
      total++;
      if (obs !== 8'b1_0000_00_1)
         $display("FAIL all_locked got %b want %b", obs, 8'b1_0000_00_1);
      else pass_cnt++;
      do_commit();
      total++;
      if ({victim_valid, victim_none} !== 2'b00)
         $display("FAIL none_commit got %b want 00",
                  {victim_valid, victim_none});
      else pass_cnt++;
      way_lock = 4'h0;
      do_req();
      total++;
      if (obs !== 8'b1_1000_11_0)
         $display("FAIL rr_after_none got %b want %b", obs, 8'b1_1000_11_0);
      else pass_cnt++;
      do_commit();
   endtask

   task automatic test_fixed();
      mode = 2'd0; fixed_way = 2'd3; way_valid = 4'hF; way_lock = 4'h0;
      do_req();
      total++;
      if (obs !== 8'b1_1000_11_0)
         $display("FAIL fixed_way got %b want %b", obs, 8'b1_1000_11_0);
      else pass_cnt++;
      do_commit();
      way_lock = 4'b1000;
      do_req();
      total++;
      if (obs !== 8'b1_0000_00_1)
         $display("FAIL fixed_locked got %b want %b", obs, 8'b1_0000_00_1);
      else pass_cnt++;
      do_commit();
   endtask

   task automatic test_lfsr();
      mode = 2'd2; way_valid = 4'hF; way_lock = 4'h0;
      do_reset();
      do_req();
      total++;
      if (obs !== 8'b1_0010_01_0)
         $display("FAIL lfsr_first got %b want %b", obs, 8'b1_0010_01_0);
      else pass_cnt++;
      do_commit();
      way_lock = 4'b0010;
      do_reset();
      do_req();
      total++;
      if (obs !== 8'b1_0100_10_0)
         $display("FAIL lfsr_lock got %b want %b", obs, 8'b1_0100_10_0);
      else pass_cnt++;
      do_commit();
   endtask

   task automatic test_hold();
      mode = 2'd1; way_valid = 4'hF; way_lock = 4'h0;
      do_reset();
      do_req();
      do_commit();
      do_req();
      total++;
      if (obs !== 8'b1_0010_01_0)
         $display("FAIL hold_setup got %b want %b", obs, 8'b1_0010_01_0);
      else pass_cnt++;
      way_valid = 4'b0000; mode = 2'd0; fixed_way = 2'd3;
      do_req();
      @(posedge clock); #1;
      total++;
      if (obs !== 8'b1_0010_01_0)
         $display("FAIL hold_frozen got %b want %b", obs, 8'b1_0010_01_0);
      else pass_cnt++;
      #2 reset = 1'b1;
      #1;
      total++;
      if (obs !== 8'b0_0000_00_0)
         $display("FAIL async_reset got %b want %b", obs, 8'b0_0000_00_0);
      else pass_cnt++;
      #1 reset = 1'b0;
      mode = 2'd1; way_valid = 4'hF;
      @(posedge clock); #1;
      do_commit();
      total++;
      if (obs !== 8'b0_0000_00_0)
         $display("FAIL idle_after_reset got %b want %b", obs,
                  8'b0_0000_00_0);
      else pass_cnt++;
      do_req();
      total++;
      if (obs !== 8'b1_0001_00_0)
         $display("FAIL rr_cleared got %b want %b", obs, 8'b1_0001_00_0);
      else pass_cnt++;
      do_commit();
   endtask

   initial begin
      test_reset();
      test_rr_wrap();
      test_invalid_pref();
      test_rr_lock();
      test_fixed();
      test_lfsr();
      test_hold();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
